// File: rtl/mips_mc.sv
// Multi-cycle MIPS core (addu/subu/ori/lui/lw/sw/beq/j/jal/jr) with one shared
// instruction/data memory port and an internal 32x32 register file.
module mips_mc #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          MEM_AW   = 10
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       pc_dbg,
   output logic              reg_we_dbg,
   output logic [4:0]        reg_addr_dbg,
   output logic [31:0]       reg_data_dbg
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

   typedef enum logic [3:0] {
      I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR
   } instr_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   state_t      state, state_next;
   instr_t      instr;
   logic [31:0] pc, ir, a, b, alu_out, mdr;
   logic [31:0] grf [32];

   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] imm_sext, imm_zext;
   logic        reg_we;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;

   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign imm      = ir[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   // Anything not recognised here falls through as a two-cycle nop.
   always_comb begin
      instr = I_NOP;
      case (ir[31:26])
         OP_RTYPE: begin
            case (ir[5:0])
               FN_ADDU: instr = I_ADDU;
               FN_SUBU: instr = I_SUBU;
               FN_JR:   instr = I_JR;
               default: instr = I_NOP;
            endcase
         end
         OP_J:    instr = I_J;
         OP_JAL:  instr = I_JAL;
         OP_BEQ:  instr = I_BEQ;
         OP_ORI:  instr = I_ORI;
         OP_LUI:  instr = I_LUI;
         OP_LW:   instr = I_LW;
         OP_SW:   instr = I_SW;
         default: instr = I_NOP;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      reg_we     = 1'b0;
      reg_addr   = '0;
      reg_data   = '0;
      case (state)
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc[MEM_AW+1:2];
            if (mem_ready) state_next = DECODE;
         end
         DECODE: begin
            case (instr)
               I_J, I_NOP: state_next = FETCH;
               I_JAL: begin
                  state_next = FETCH;
                  reg_we     = 1'b1;
                  reg_addr   = 5'd31;
                  reg_data   = pc;
               end
               default: state_next = EXEC;
            endcase
         end
         EXEC: begin
            case (instr)
               I_ADDU, I_SUBU, I_ORI, I_LUI: state_next = WB;
               I_LW, I_SW:                   state_next = MEM;
               default:                      state_next = FETCH;
            endcase
         end
         MEM: begin
            mem_req  = 1'b1;
            mem_we   = (instr == I_SW);
            mem_addr = alu_out[MEM_AW+1:2];
            if (instr == I_SW) mem_wdata = b;
            if (mem_ready) state_next = (instr == I_LW) ? WB : FETCH;
         end
         WB: begin
            reg_we     = 1'b1;
            reg_addr   = (instr == I_ADDU || instr == I_SUBU) ? rd : rt;
            reg_data   = (instr == I_LW) ? mdr : alu_out;
            state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
      // The reset cycle must not issue a bus request or a register write.
      if (reset) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         reg_we  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         // NOTE: the register file is architecturally cleared by reset, so it
         // is built from resettable flops rather than a RAM macro.
         for (int i = 0; i < 32; i++) grf[i] <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + 32'd4;
               end
            end
            DECODE: begin
               a <= grf[rs];
               b <= grf[rt];
               if (instr == I_J || instr == I_JAL) pc <= {pc[31:28], ir[25:0], 2'b00};
            end
            EXEC: begin
               case (instr)
                  I_ADDU:     alu_out <= a + b;
                  I_SUBU:     alu_out <= a - b;
                  I_ORI:      alu_out <= a | imm_zext;
                  I_LUI:      alu_out <= {imm, 16'h0000};
                  I_LW, I_SW: alu_out <= a + imm_sext;
                  I_BEQ:      if (a == b) pc <= pc + {imm_sext[29:0], 2'b00};
                  I_JR:       pc <= a;
                  default:    ;
               endcase
            end
            MEM: begin
               if (mem_ready && instr == I_LW) mdr <= mem_rdata;
            end
            default: ;
         endcase
         // $0 is never written; it keeps its reset value of zero.
         if (reg_we && reg_addr != 5'd0) grf[reg_addr] <= reg_data;
      end
   end

   assign pc_dbg       = pc;
   assign reg_we_dbg   = reg_we;
   assign reg_addr_dbg = reg_addr;
   assign reg_data_dbg = reg_data;

endmodule
